demux_1xn_stream: RTL and testbench
===================================

// Module: demux_1xn_stream
// PURPOSE
//  - Parametrised 1-to-N stream demultiplexer; successor to the 1x2 combinational demux.
//  - Routes each input word to channel `in_sel` through a one-entry registered output slot per channel.
//  - Uses valid/ready handshakes on the input and on every output.
//  - Sits between a single producer and N independent consumers. Back-pressure on one channel stalls only words aimed at it.
// PARAMETERS
//  - N_CH   4   number of output channels, >=2
//  - DATA_W 8   data width in bits, >=1
//  - SEL_W  $clog2(N_CH)   select width (localparam, not overridable)
// PORTS
//  - clk        in   1         single clock, rising edge
//  - rst_n      in   1         asynchronous assert, active-low reset
//  - in_data    in   DATA_W    input word
//  - in_sel     in   SEL_W     destination channel
//  - in_valid   in   1         input word present
//  - in_ready   out  1         block can accept the input this cycle
//  - out_data   out  N_CH*DATA_W  channel k occupies [k*DATA_W +: DATA_W]
//  - out_valid  out  N_CH      channel k slot holds a word
//  - out_ready  in   N_CH      consumer k takes the word
//  - sel_err    out  1         registered 1-cycle pulse: a word with in_sel>=N_CH was dropped
// BEHAVIOUR
//  - Reset: all slots EMPTY; out_valid=0, out_data=0, sel_err=0. No stale word survives reset.
//  - Reset asserted mid-transfer discards all held words.
//  - Per-channel 2-state FSM, EMPTY/FULL:
//    - EMPTY->FULL on load.
//    - FULL->EMPTY on (out_ready[k] & !load).
//    - FULL->FULL on load (pass-through refill, same cycle as drain allowed).
//  - load_k = in_valid & in_ready & (in_sel==k).
//  - in_ready (combinational, no dependence on in_valid):
//    - in_sel<N_CH: in_ready = !out_valid[in_sel] | out_ready[in_sel].
//    - in_sel>=N_CH: in_ready = 1. The word is accepted and dropped; sel_err=1 next cycle.
//  - Latency: an accepted word appears on out_data/out_valid of its channel the next cycle. Throughput is 1 word/cycle/channel.
//  - A channel's out_data is zeroed when it goes EMPTY, so an idle channel drives 0. This matches the legacy unselected-output behaviour.
//  - Channels are independent. A FULL, stalled channel k never blocks words to j!=k.
//  - out_ready on an EMPTY channel is ignored.
//  - Only one channel can load per cycle; no other simultaneous-load case exists.
//  - in_sel/in_data need only be stable while in_valid=1 and in_ready=0.
// CONFIGURATION
//  - Macro DEMUX_STATS_EN.
//  - Defined: adds output port xfer_cnt, N_CH*16 bits.
//    - One 16-bit counter per channel increments on each out_valid&out_ready. It wraps 0xFFFF->0.
//    - Also adds a 16-bit drop_cnt output incremented with sel_err, wrapping.
//    - All counters reset to 0.
//  - Undefined: these ports and counters do not exist. All other behaviour is identical.
// STRUCTURE
//  - Package demux_pkg holds:
//    - ch_state_e {CH_EMPTY, CH_FULL}
//    - localparam STAT_W=16
//  - Sub-module demux_slot: one channel's FSM plus data register, with valid/ready on both sides. Instantiate N_CH times via generate.
//  - Top level holds the select decode, in_ready mux, sel_err register and the optional counters.
// TESTING
//  - Reset: hold rst_n=0 with in_valid=1 -> out_valid=0, out_data=0, sel_err=0. Release rst_n -> first load lands in the following cycle.
//  - Routing: N_CH=4, out_ready=4'hF, send 0xA1..0xA4 with sel 0..3 back-to-back -> each channel shows its word exactly 1 cycle later; all other channels show 0.
//  - Back-pressure: out_ready[2]=0, send 0x55 then 0x66 both to sel=2.
//    - 0x55 is held and in_ready=0 for the second word.
//    - A word to sel=1 is still accepted meanwhile.
//    - Raise out_ready[2] -> 0x66 loads in that same cycle.
//  - Refill: channel 0 FULL with out_ready[0]=1 and a new load to sel=0 in the same cycle -> out_valid[0] stays 1 and data updates with no bubble.
//  - Invalid select: N_CH=3, send sel=3 -> in_ready=1, no out_valid rises, sel_err pulses exactly 1 cycle. Add drop_cnt=1 with DEMUX_STATS_EN.
//  - Mid-op reset: three channels FULL, pulse rst_n low asynchronously between edges -> all out_valid drop immediately; counters read 0.

Source files
------------

// File: rtl/demux_pkg.sv
// Shared types for the 1-to-N stream demultiplexer.
// Optional statistics counters are enabled by DEMUX_STATS_EN.
package demux_pkg;

    typedef enum logic {
        CH_EMPTY = 1'b0,
        CH_FULL  = 1'b1
    } ch_state_e;

    localparam int STAT_W = 16;

endpackage

// File: rtl/demux_slot.sv
// One output channel: EMPTY/FULL FSM plus a one-word data register.
// Build option DEMUX_STATS_EN lives in the top level only.
module demux_slot
    import demux_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready
);

    ch_state_e state_q;
    logic      load;

    // A full slot can still take a word when the consumer drains it this cycle.
    assign in_ready  = (state_q == CH_EMPTY) | out_ready;
    assign load      = in_valid & in_ready;
    assign out_valid = (state_q == CH_FULL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= CH_EMPTY;
            out_data <= '0;
        end else begin
            unique case (state_q)
                CH_EMPTY: begin
                    if (load) begin
                        state_q  <= CH_FULL;
                        out_data <= in_data;
                    end
                end
                CH_FULL: begin
                    if (load) begin
                        out_data <= in_data;
                    end else if (out_ready) begin
                        state_q  <= CH_EMPTY;
                        out_data <= '0;
                    end
                end
                default: begin
                    state_q  <= CH_EMPTY;
                    out_data <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/demux_1xn_stream.sv
// 1-to-N valid/ready stream demux with a registered slot per channel.
// Define DEMUX_STATS_EN to add xfer_cnt/drop_cnt statistics ports.
module demux_1xn_stream
    import demux_pkg::*;
#(
    parameter  int N_CH   = 4,
    parameter  int DATA_W = 8,
    localparam int SEL_W  = $clog2(N_CH)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [DATA_W-1:0]      in_data,
    input  logic [SEL_W-1:0]       in_sel,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [N_CH*DATA_W-1:0] out_data,
    output logic [N_CH-1:0]        out_valid,
    input  logic [N_CH-1:0]        out_ready,
    output logic                   sel_err
`ifdef DEMUX_STATS_EN
    ,
    output logic [N_CH*STAT_W-1:0] xfer_cnt,
    output logic [STAT_W-1:0]      drop_cnt
`endif
);

    logic [N_CH-1:0] hit;
    logic [N_CH-1:0] slot_rdy;
    logic            bad_sel;

    genvar k;
    generate
        for (k = 0; k < N_CH; k++) begin : g_ch
            assign hit[k] = (in_sel == SEL_W'(k));

            demux_slot #(
                .DATA_W (DATA_W)
            ) u_slot (
                .clk       (clk),
                .rst_n     (rst_n),
                .in_data   (in_data),
                .in_valid  (in_valid & hit[k]),
                .in_ready  (slot_rdy[k]),
                .out_data  (out_data[k*DATA_W +: DATA_W]),
                .out_valid (out_valid[k]),
                .out_ready (out_ready[k])
            );
        end
    endgenerate

    // An out-of-range select matches no channel: accept and drop the word.
    assign bad_sel = in_valid & ~|hit;

    always_comb begin
        in_ready = 1'b1;
        for (int i = 0; i < N_CH; i++) begin
            if (hit[i]) in_ready = slot_rdy[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sel_err <= 1'b0;
        else        sel_err <= bad_sel;
    end

`ifdef DEMUX_STATS_EN
    logic [STAT_W-1:0] xfer_q [N_CH];

    generate
        for (k = 0; k < N_CH; k++) begin : g_stat
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    xfer_q[k] <= '0;
                end else if (out_valid[k] & out_ready[k]) begin
                    xfer_q[k] <= xfer_q[k] + STAT_W'(1);
                end
            end

            assign xfer_cnt[k*STAT_W +: STAT_W] = xfer_q[k];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       drop_cnt <= '0;
        else if (bad_sel) drop_cnt <= drop_cnt + STAT_W'(1);
    end
`endif

endmodule

// File: tb/tb_demux_1xn_stream.sv
// Directed self-checking bench: a 4-channel and a 3-channel instance.
// Statistics checks are compiled in when DEMUX_STATS_EN is defined.
module tb_demux_1xn_stream;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [7:0]  d4;
    logic [1:0]  s4;
    logic        v4;
    logic        r4;
    logic [31:0] od4;
    logic [3:0]  ov4;
    logic [3:0]  ordy4;
    logic        e4;

    logic [7:0]  d3;
    logic [1:0]  s3;
    logic        v3;
    logic        r3;
    logic [23:0] od3;
    logic [2:0]  ov3;
    logic [2:0]  ordy3;
    logic        e3;

`ifdef DEMUX_STATS_EN
    logic [63:0] xc4;
    logic [15:0] dc4;
    logic [47:0] xc3;
    logic [15:0] dc3;
`endif

    int nvec = 0;
    int nerr = 0;

    demux_1xn_stream #(.N_CH(4), .DATA_W(8)) u4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (d4),
        .in_sel    (s4),
        .in_valid  (v4),
        .in_ready  (r4),
        .out_data  (od4),
        .out_valid (ov4),
        .out_ready (ordy4),
        .sel_err   (e4)
`ifdef DEMUX_STATS_EN
        ,
        .xfer_cnt  (xc4),
        .drop_cnt  (dc4)
`endif
    );

    demux_1xn_stream #(.N_CH(3), .DATA_W(8)) u3 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (d3),
        .in_sel    (s3),
        .in_valid  (v3),
        .in_ready  (r3),
        .out_data  (od3),
        .out_valid (ov3),
        .out_ready (ordy3),
        .sel_err   (e3)
`ifdef DEMUX_STATS_EN
        ,
        .xfer_cnt  (xc3),
        .drop_cnt  (dc3)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        v4 = 1'b1; s4 = 2'd0; d4 = 8'h77; ordy4 = 4'hF;
        v3 = 1'b0; s3 = 2'd0; d3 = 8'h00; ordy3 = 3'h7;
        tick();
        tick();
        nvec++; if (ov4 !== 4'h0) begin nerr++; $display("FAIL rst_ov4 got %h exp 0", ov4); end
        nvec++; if (od4 !== 32'h0) begin nerr++; $display("FAIL rst_od4 got %h exp 0", od4); end
        nvec++; if (e4 !== 1'b0) begin nerr++; $display("FAIL rst_err4 got %b exp 0", e4); end
        nvec++; if (ov3 !== 3'h0) begin nerr++; $display("FAIL rst_ov3 got %h exp 0", ov3); end
        rst_n = 1'b1;
        tick();
        nvec++; if (ov4 !== 4'h1) begin nerr++; $display("FAIL rel_ov4 got %h exp 1", ov4); end
        nvec++; if (od4 !== 32'h77) begin nerr++; $display("FAIL rel_od4 got %h exp 77", od4); end
        v4 = 1'b0;
        tick();
        nvec++; if (ov4 !== 4'h0) begin nerr++; $display("FAIL rel_drain got %h exp 0", ov4); end
        nvec++; if (od4 !== 32'h0) begin nerr++; $display("FAIL rel_zero got %h exp 0", od4); end
    endtask

    task automatic test_routing();
        logic [31:0] exp_d;
        logic [3:0]  exp_v;
        ordy4 = 4'hF;
        for (int i = 0; i < 4; i++) begin
            v4 = 1'b1; s4 = 2'(i); d4 = 8'hA1 + 8'(i);
            #1;
            nvec++; if (r4 !== 1'b1) begin nerr++; $display("FAIL route_rdy%0d got %b exp 1", i, r4); end
            tick();
            exp_d = '0;
            exp_d[8*i +: 8] = 8'hA1 + 8'(i);
            exp_v = 4'(1 << i);
            nvec++; if (ov4 !== exp_v) begin nerr++; $display("FAIL route_ov%0d got %h exp %h", i, ov4, exp_v); end
            nvec++; if (od4 !== exp_d) begin nerr++; $display("FAIL route_od%0d got %h exp %h", i, od4, exp_d); end
        end
        v4 = 1'b0;
        tick();
        nvec++; if (ov4 !== 4'h0) begin nerr++; $display("FAIL route_idle got %h exp 0", ov4); end
        nvec++; if (e4 !== 1'b0) begin nerr++; $display("FAIL route_err got %b exp 0", e4); end
    endtask

    task automatic test_back_to_back();
        ordy4 = 4'b1011;
        v4 = 1'b1; s4 = 2'd2; d4 = 8'h55;
        #1;
        nvec++; if (r4 !== 1'b1) begin nerr++; $display("FAIL bp_rdy1 got %b exp 1", r4); end
        tick();
        nvec++; if (ov4 !== 4'b0100) begin nerr++; $display("FAIL bp_ov1 got %h exp 4", ov4); end
        nvec++; if (od4 !== 32'h0055_0000) begin nerr++; $display("FAIL bp_od1 got %h exp 00550000", od4); end
        d4 = 8'h66;
        #1;
        nvec++; if (r4 !== 1'b0) begin nerr++; $display("FAIL bp_stall got %b exp 0", r4); end
        tick();
        nvec++; if (od4 !== 32'h0055_0000) begin nerr++; $display("FAIL bp_hold got %h exp 00550000", od4); end
        s4 = 2'd1; d4 = 8'h31;
        #1;
        nvec++; if (r4 !== 1'b1) begin nerr++; $display("FAIL bp_other_rdy got %b exp 1", r4); end
        tick();
        nvec++; if (ov4 !== 4'b0110) begin nerr++; $display("FAIL bp_ov2 got %h exp 6", ov4); end
        nvec++; if (od4 !== 32'h0055_3100) begin nerr++; $display("FAIL bp_od2 got %h exp 00553100", od4); end
        s4 = 2'd2; d4 = 8'h66;
        #1;
        nvec++; if (r4 !== 1'b0) begin nerr++; $display("FAIL bp_stall2 got %b exp 0", r4); end
        ordy4 = 4'hF;
        #1;
        nvec++; if (r4 !== 1'b1) begin nerr++; $display("FAIL bp_release got %b exp 1", r4); end
        tick();
        nvec++; if (ov4 !== 4'b0100) begin nerr++; $display("FAIL bp_ov3 got %h exp 4", ov4); end
        nvec++; if (od4 !== 32'h0066_0000) begin nerr++; $display("FAIL bp_od3 got %h exp 00660000", od4); end
        v4 = 1'b0;
        tick();
        nvec++; if (ov4 !== 4'h0) begin nerr++; $display("FAIL bp_idle got %h exp 0", ov4); end
    endtask

    task automatic test_refill();
        logic [7:0] w [3];
        w[0] = 8'h10; w[1] = 8'h20; w[2] = 8'h30;
        ordy4 = 4'hF;
        for (int i = 0; i < 3; i++) begin
            v4 = 1'b1; s4 = 2'd0; d4 = w[i];
            #1;
            nvec++; if (r4 !== 1'b1) begin nerr++; $display("FAIL refill_rdy%0d got %b exp 1", i, r4); end
            tick();
            nvec++; if (ov4 !== 4'h1) begin nerr++; $display("FAIL refill_ov%0d got %h exp 1", i, ov4); end
            nvec++; if (od4 !== {24'h0, w[i]}) begin nerr++; $display("FAIL refill_od%0d got %h exp %h", i, od4, w[i]); end
        end
        v4 = 1'b0;
        tick();
        nvec++; if (ov4 !== 4'h0) begin nerr++; $display("FAIL refill_idle got %h exp 0", ov4); end
    endtask

    task automatic test_invalid_sel();
        ordy3 = 3'h7;
        v3 = 1'b1; s3 = 2'd3; d3 = 8'hEE;
        #1;
        nvec++; if (r3 !== 1'b1) begin nerr++; $display("FAIL bad_rdy got %b exp 1", r3); end
        tick();
        nvec++; if (ov3 !== 3'h0) begin nerr++; $display("FAIL bad_ov got %h exp 0", ov3); end
        nvec++; if (e3 !== 1'b1) begin nerr++; $display("FAIL bad_err got %b exp 1", e3); end
        s3 = 2'd2; d3 = 8'h42;
        tick();
        nvec++; if (e3 !== 1'b0) begin nerr++; $display("FAIL bad_pulse got %b exp 0", e3); end
        nvec++; if (ov3 !== 3'b100) begin nerr++; $display("FAIL n3_ov got %h exp 4", ov3); end
        nvec++; if (od3 !== 24'h42_0000) begin nerr++; $display("FAIL n3_od got %h exp 420000", od3); end
        v3 = 1'b0;
        tick();
        nvec++; if (ov3 !== 3'h0) begin nerr++; $display("FAIL n3_idle got %h exp 0", ov3); end
`ifdef DEMUX_STATS_EN
        nvec++; if (dc3 !== 16'd1) begin nerr++; $display("FAIL drop_cnt3 got %0d exp 1", dc3); end
        nvec++; if (xc3 !== {16'd1, 16'd0, 16'd0}) begin nerr++; $display("FAIL xfer_cnt3 got %h", xc3); end
        nvec++; if (dc4 !== 16'd0) begin nerr++; $display("FAIL drop_cnt4 got %0d exp 0", dc4); end
        nvec++; if (xc4 !== {16'd1, 16'd3, 16'd2, 16'd5}) begin nerr++; $display("FAIL xfer_cnt4 got %h exp 0001000300020005", xc4); end
`endif
    endtask

    task automatic test_midop_reset();
        ordy4 = 4'h0;
        v4 = 1'b1;
        s4 = 2'd0; d4 = 8'h01; tick();
        s4 = 2'd1; d4 = 8'h02; tick();
        s4 = 2'd3; d4 = 8'h04; tick();
        v4 = 1'b0;
        nvec++; if (ov4 !== 4'b1011) begin nerr++; $display("FAIL mid_ov got %h exp b", ov4); end
        nvec++; if (od4 !== 32'h0400_0201) begin nerr++; $display("FAIL mid_od got %h exp 04000201", od4); end
        #2;
        rst_n = 1'b0;
        #1;
        nvec++; if (ov4 !== 4'h0) begin nerr++; $display("FAIL arst_ov got %h exp 0", ov4); end
        nvec++; if (od4 !== 32'h0) begin nerr++; $display("FAIL arst_od got %h exp 0", od4); end
`ifdef DEMUX_STATS_EN
        nvec++; if (xc4 !== 64'h0) begin nerr++; $display("FAIL arst_xfer got %h exp 0", xc4); end
        nvec++; if (dc3 !== 16'h0) begin nerr++; $display("FAIL arst_drop got %h exp 0", dc3); end
`endif
        #1;
        rst_n = 1'b1;
        ordy4 = 4'hF;
        tick();
        nvec++; if (ov4 !== 4'h0) begin nerr++; $display("FAIL post_arst got %h exp 0", ov4); end
    endtask

    initial begin
        test_reset();
        test_routing();
        test_back_to_back();
        test_refill();
        test_invalid_sel();
        test_midop_reset();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
